// File: rtl/pio_in_edge_pkg.sv
// ---------------------------------------------------------------------------
// pio_in_pkg
//
// Purpose:
//   Shared definitions for the pio_in_edge input PIO: the register word
//   addresses, the CTRL bit position of the interrupt mode, the interrupt
//   mode enumeration and a small bus-decode helper.
//
// Contents:
//   ADDR_*        3-bit word addresses of the register map
//   IRQ_MODE_BIT  bit index of IRQ_MODE inside CTRL
//   irq_mode_e    IRQ_LEVEL (irq follows masked filtered input) or
//                 IRQ_EDGE  (irq follows masked edge captures)
//   busWrite()    true when the slave sees a write strobe this cycle
// ---------------------------------------------------------------------------
package pio_in_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_RISE = 3'd4;
    localparam logic [2:0] ADDR_FALL = 3'd5;
    localparam logic [2:0] ADDR_CTRL = 3'd6;
    localparam logic [2:0] ADDR_DBTH = 3'd7;

    localparam int IRQ_MODE_BIT = 0;

    typedef enum logic {
        IRQ_LEVEL = 1'b0,
        IRQ_EDGE  = 1'b1
    } irq_mode_e;

    // A write happens on any cycle the slave is selected with write_n low;
    // there are no wait states, so this is the complete write qualifier.
    function automatic logic busWrite(input logic chipselect, input logic write_n);
        return chipselect & ~write_n;
    endfunction

endpackage

// File: rtl/pio_in_edge_if.sv
// ---------------------------------------------------------------------------
// pio_in_edge_if
//
// Purpose:
//   Avalon-MM slave bus bundle for the pio_in_edge input PIO.
//
// Signals:
//   address     3   word address
//   chipselect  1   slave select
//   write_n     1   active-low write strobe
//   writedata   32  write data
//   readdata    32  registered read data (one cycle latency)
//
// Modports:
//   master  drives address/chipselect/write_n/writedata, samples readdata
//   slave   samples the request signals, drives readdata
// ---------------------------------------------------------------------------
interface pio_in_edge_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/pio_in_edge_debounce.sv
// ---------------------------------------------------------------------------
// pio_in_debounce
//
// Purpose:
//   Single-bit counter filter. The filtered output only follows the
//   synchronised input once that input has disagreed with the current
//   filtered value for i_thresh+1 consecutive cycles. A threshold of 0
//   therefore behaves as a plain one-cycle register.
//
//   The module body is only present when PIO_IN_DEBOUNCE_EN is defined,
//   because it is only instantiated in that build.
//
// Parameters:
//   DB_W      counter / threshold width
//
// Ports:
//   clk       in   1     system clock
//   reset_n   in   1     synchronous active-low reset
//   i_sync    in   1     synchronised input bit
//   i_thresh  in   DB_W  number of extra stable cycles required
//   o_filt    out  1     filtered (debounced) bit
// ---------------------------------------------------------------------------
`ifdef PIO_IN_DEBOUNCE_EN
module pio_in_debounce #(
    parameter int DB_W = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_sync,
    input  logic [DB_W-1:0] i_thresh,
    output logic            o_filt
);

    logic [DB_W-1:0] r_count;
    logic            r_filt;

    // The counter measures how long the input has been sitting at the
    // opposite value of the filtered output. Any return to agreement throws
    // the run away, so a glitch shorter than the threshold never gets
    // through. Comparing with >= keeps the filter well behaved if firmware
    // lowers the threshold while a count is already above it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
            r_filt  <= 1'b0;
        end else if (i_sync == r_filt) begin
            r_count <= '0;
        end else if (r_count >= i_thresh) begin
            r_filt  <= i_sync;
            r_count <= '0;
        end else begin
            r_count <= r_count + DB_W'(1);
        end
    end

    assign o_filt = r_filt;

endmodule
`endif

// File: rtl/pio_in_edge.sv
// ---------------------------------------------------------------------------
// pio_in_edge
//
// Purpose:
//   Avalon-MM input PIO with per-bit rising/falling edge selection,
//   write-1-to-clear edge capture, level or edge interrupt mode and an
//   optional per-bit debounce filter.
//
// Configuration macro:
//   PIO_IN_DEBOUNCE_EN  when defined, every input bit gets a DB_W-bit
//                       debounce counter and DB_THRESH exists at address 7.
//                       When undefined, the filter stage is a plain
//                       register and address 7 reads 0.
//
// Parameters:
//   WIDTH        number of input bits (1..32)
//   SYNC_STAGES  synchroniser depth (2..4)
//   DB_W         debounce counter width (debounce build only)
//   RISE_RST     reset value of RISE_EN
//   FALL_RST     reset value of FALL_EN
//
// Ports:
//   clk       in   1      system clock
//   reset_n   in   1      synchronous active-low reset
//   bus       slave       Avalon-MM register interface (pio_in_edge_if)
//   in_port   in   WIDTH  asynchronous external inputs
//   irq       out  1      registered interrupt request, active high
//
// Register map (word addresses, WIDTH bits LSB aligned, rest reads 0):
//   0 DATA (RO)  2 IRQ_MASK  3 EDGE_CAPTURE (W1C)  4 RISE_EN  5 FALL_EN
//   6 CTRL (bit0 IRQ_MODE)  7 DB_THRESH (debounce build only)
// ---------------------------------------------------------------------------
module pio_in_edge
    import pio_in_pkg::*;
#(
    parameter int               WIDTH       = 2,
    parameter int               SYNC_STAGES = 2,
    parameter int               DB_W        = 16,
    parameter logic [WIDTH-1:0] RISE_RST    = '1,
    parameter logic [WIDTH-1:0] FALL_RST    = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    pio_in_edge_if.slave     bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_syncOut;
    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] r_prev;

    logic [WIDTH-1:0] r_irqMask;
    logic [WIDTH-1:0] r_edgeCap;
    logic [WIDTH-1:0] r_riseEn;
    logic [WIDTH-1:0] r_fallEn;
    irq_mode_e        r_irqMode;

    logic [31:0]      r_readdata;
    logic [31:0]      w_readMux;
    logic             r_irq;

    logic             w_write;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edgeDetect;
    logic [WIDTH-1:0] w_edgeClear;

    // Only the low WIDTH (or DB_W) bits of writedata are stored; the rest is
    // folded here so the upper bits are visibly consumed.
    logic             w_unusedWdata;

    assign w_write       = busWrite(bus.chipselect, bus.write_n);
    assign w_unusedWdata = ^bus.writedata;

    // Metastability synchroniser: in_port is asynchronous, so it walks
    // through SYNC_STAGES flops before anything else looks at it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_syncOut = r_sync[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
    logic [DB_W-1:0] r_dbThresh;

    // Debounce threshold register. It resets to the slowest possible filter
    // so that inputs do not chatter before firmware has configured it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dbThresh <= '1;
        end else if (w_write && bus.address == ADDR_DBTH) begin
            r_dbThresh <= bus.writedata[DB_W-1:0];
        end
    end

    // One independent counter filter per input bit, all sharing the same
    // threshold.
    for (genvar g = 0; g < WIDTH; g++) begin : g_debounce
        pio_in_debounce #(
            .DB_W(DB_W)
        ) u_debounce (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_sync   (w_syncOut[g]),
            .i_thresh (r_dbThresh),
            .o_filt   (w_filt[g])
        );
    end
`else
    logic [WIDTH-1:0] r_filt;
    logic [DB_W-1:0]  w_unusedDbWidth;

    // Without debounce the filter stage is just one more register, which
    // keeps the DATA latency identical to a debounce build with threshold 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_filt <= '0;
        end else begin
            r_filt <= w_syncOut;
        end
    end

    assign w_filt          = r_filt;
    assign w_unusedDbWidth = '0;
`endif

    // The previous filtered value gives us a one-cycle history for edge
    // detection. Each direction is enabled per bit independently.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_filt;
        end
    end

    assign w_rise       = w_filt & ~r_prev & r_riseEn;
    assign w_fall       = ~w_filt & r_prev & r_fallEn;
    assign w_edgeDetect = w_rise | w_fall;
    assign w_edgeClear  = (w_write && bus.address == ADDR_EDGE) ?
                          bus.writedata[WIDTH-1:0] : '0;

    // Edge capture: the clear is applied first and the new edges are OR-ed
    // in afterwards, so an edge arriving in the same cycle as a W1C of the
    // same bit survives and no event is ever lost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_edgeCap <= '0;
        end else begin
            r_edgeCap <= (r_edgeCap & ~w_edgeClear) | w_edgeDetect;
        end
    end

    // Plain read/write configuration registers. Changing the edge enables
    // deliberately leaves already captured edges untouched.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_irqMask <= '0;
            r_riseEn  <= RISE_RST;
            r_fallEn  <= FALL_RST;
            r_irqMode <= IRQ_LEVEL;
        end else if (w_write) begin
            case (bus.address)
                ADDR_MASK: r_irqMask <= bus.writedata[WIDTH-1:0];
                ADDR_RISE: r_riseEn  <= bus.writedata[WIDTH-1:0];
                ADDR_FALL: r_fallEn  <= bus.writedata[WIDTH-1:0];
                ADDR_CTRL: r_irqMode <= irq_mode_e'(bus.writedata[IRQ_MODE_BIT]);
                default:   ;
            endcase
        end
    end

    // Read mux. Every register is zero-extended to 32 bits; address 1 and,
    // in the plain build, address 7 fall through to the zero default.
    always_comb begin
        w_readMux = '0;
        case (bus.address)
            ADDR_DATA: w_readMux[WIDTH-1:0]     = w_filt;
            ADDR_MASK: w_readMux[WIDTH-1:0]     = r_irqMask;
            ADDR_EDGE: w_readMux[WIDTH-1:0]     = r_edgeCap;
            ADDR_RISE: w_readMux[WIDTH-1:0]     = r_riseEn;
            ADDR_FALL: w_readMux[WIDTH-1:0]     = r_fallEn;
            ADDR_CTRL: w_readMux[IRQ_MODE_BIT]  = r_irqMode;
`ifdef PIO_IN_DEBOUNCE_EN
            ADDR_DBTH: w_readMux[DB_W-1:0]      = r_dbThresh;
`endif
            default:   ;
        endcase
    end

    // readdata is registered every cycle regardless of chipselect, which
    // gives the fixed one-cycle read latency the bridge expects.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_readMux;
        end
    end

    // Interrupt request, registered to keep the GIC input glitch free.
    // Level mode watches the filtered inputs; edge mode watches captures.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else if (r_irqMode == IRQ_EDGE) begin
            r_irq <= |(r_edgeCap & r_irqMask);
        end else begin
            r_irq <= |(w_filt & r_irqMask);
        end
    end

    assign bus.readdata = r_readdata;
    assign irq          = r_irq;

endmodule
